// File: rtl/data_mem_pkg.sv
// Shared types and geometry helpers for the handshaked data memory.
package data_mem_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  typedef struct packed {
    int lanes;
    int shift;
  } memGeom_t;

  // Byte lanes per word and the byte-address shift that yields the word index.
  function automatic memGeom_t memGeom(input int dataWidth);
    memGeom_t g;
    g.lanes = dataWidth / 8;
    g.shift = $clog2(dataWidth / 8);
    return g;
  endfunction

endpackage

// File: rtl/data_mem_rsp_fifo.sv
// Two-entry in-order response FIFO; dout reads as zero while empty.
module data_mem_rsp_fifo #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entries [2];
  logic             wrPtr;
  logic             rdPtr;
  logic             doPush;
  logic             doPop;

  assign doPop  = pop && (count != 2'd0);
  assign doPush = push && ((count != 2'd2) || doPop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (doPush) wrPtr <= ~wrPtr;
      if (doPop)  rdPtr <= ~rdPtr;
      count <= count + 2'(doPush) - 2'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) entries[wrPtr] <= din;
  end

  assign dout = (count != 2'd0) ? entries[rdPtr] : '0;

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked byte-lane data memory with address checks, 2-deep response
// buffer and an optional zeroing sweep after reset.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_write,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam memGeom_t GEOM  = memGeom(DATA_WIDTH);
  localparam int       LANES = GEOM.lanes;
  localparam int       SHIFT = GEOM.shift;
  localparam int       IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(LANES - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  write;
    logic                  err;
  } rspEntry_t;

  state_t                state;
  state_t                stateNext;
  logic [IDX_W-1:0]      clrIdx;
  logic [IDX_W-1:0]      clrIdxNext;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wordAddr;
  logic [IDX_W-1:0]      idx;
  logic                  reqErr;
  logic                  accept;
  logic [1:0]            count;
  rspEntry_t             pushEntry;
  rspEntry_t             headEntry;

  assign wordAddr = req_addr >> SHIFT;
  assign idx      = wordAddr[IDX_W-1:0];
  assign reqErr   = (|(req_addr & ALIGN_MASK)) || (wordAddr >= ADDR_WIDTH'(DEPTH));

  // Gating with reset keeps req_ready low while reset is held, whatever the FSM state.
  assign req_ready = reset && (state == RUN) && (count != 2'd2);
  assign accept    = req_valid && req_ready;
  assign busy      = (state == CLEAR);

  always_comb begin
    pushEntry.write = req_write;
    pushEntry.err   = reqErr;
    pushEntry.rdata = (!req_write && !reqErr) ? mem[idx] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= CLEAR_ON_RESET ? CLEAR : RUN;
      clrIdx <= '0;
    end else begin
      state  <= stateNext;
      clrIdx <= clrIdxNext;
    end
  end

  always_comb begin
    stateNext  = state;
    clrIdxNext = clrIdx;
    if (state == CLEAR) begin
      clrIdxNext = clrIdx + 1'b1;
      if (clrIdx == IDX_W'(DEPTH - 1)) begin
        stateNext  = RUN;
        clrIdxNext = '0;
      end
    end
  end

  // Storage: zero sweep during CLEAR, otherwise lane-masked stores.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clrIdx] <= '0;
    end else if (accept && req_write && !reqErr) begin
      for (int i = 0; i < LANES; i++) begin
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  data_mem_rsp_fifo #(
    .WIDTH($bits(rspEntry_t))
  ) uRspFifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (rsp_valid && rsp_ready),
    .din   (pushEntry),
    .dout  (headEntry),
    .count (count)
  );

  assign rsp_valid = (count != 2'd0);
  assign rsp_rdata = headEntry.rdata;
  assign rsp_write = headEntry.write;
  assign rsp_err   = headEntry.err;

endmodule
